// File: rtl/som_train_ctrl.sv
// som_train_ctrl: sequences one SOM training run over the 8x8 VEP array.
// For each sample it loads the sample, waits DIST_LAT cycles for the VEP
// distances to settle, captures the winner, then scans all 64 VEPs and
// enables weight update for those inside the current neighbourhood radius.
// The radius decays and the learning-rate shift grows once per epoch.
//
// Optional feature (macro SOM_EARLY_STOP_EN): per-sample winner memory and
// per-epoch change count; the run ends early after any epoch >= 1 in which
// no winner changed, and stopped_early reports it.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 run start pulse (ignored while busy)
//   busy, done            run in progress / end-of-run pulse
//   sample_addr           current sample index
//   sample_load           one-cycle sample latch strobe for the VEPs
//   winner_x_in/_y_in     winner coordinates from the winner-select tree
//   win_x, win_y          captured winner
//   upd_en, upd_x, upd_y  weight-update enable for the scanned VEP
//   lr_shift              current learning-rate right shift
//   epoch                 current epoch index
//   stopped_early         (SOM_EARLY_STOP_EN only) run ended by convergence
module som_train_ctrl #(
  parameter int unsigned NUM_SAMPLES = 16,
  parameter int unsigned SAMPLE_AW   = 4,
  parameter int unsigned NUM_EPOCHS  = 8,
  parameter int unsigned DIST_LAT    = 2,
  parameter int unsigned INIT_RADIUS = 3,
  parameter int unsigned INIT_SHIFT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [SAMPLE_AW-1:0] sample_addr,
  output logic                 sample_load,
  input  logic [2:0]           winner_x_in,
  input  logic [2:0]           winner_y_in,
  output logic [2:0]           win_x,
  output logic [2:0]           win_y,
  output logic                 upd_en,
  output logic [2:0]           upd_x,
  output logic [2:0]           upd_y,
  output logic [2:0]           lr_shift,
  output logic [3:0]           epoch
`ifdef SOM_EARLY_STOP_EN
  ,
  output logic                 stopped_early
`endif
);

  localparam int unsigned WAIT_W = (DIST_LAT > 1) ? $clog2(DIST_LAT) : 1;
  localparam int unsigned SCAN_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_UPD,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SCAN_W-1:0]   scan;
  logic [SCAN_W-1:0]   scan_inc;
  logic [2:0]          radius;
  logic [3:0]          epoch_inc;
  logic                last_sample;
  logic                last_epoch;
  logic                stop_early;

  // Chebyshev distance test, clipped at the array edges (no wrap).
  function automatic logic in_hood(input logic [2:0] x, input logic [2:0] y,
                                   input logic [2:0] wx, input logic [2:0] wy,
                                   input logic [2:0] r);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = (x >= wx) ? ({1'b0, x} - {1'b0, wx}) : ({1'b0, wx} - {1'b0, x});
    dy = (y >= wy) ? ({1'b0, y} - {1'b0, wy}) : ({1'b0, wy} - {1'b0, y});
    return (dx <= {1'b0, r}) && (dy <= {1'b0, r});
  endfunction

  assign scan_inc    = scan + 6'd1;
  assign epoch_inc   = epoch + 4'd1;
  assign last_sample = !(sample_addr < SAMPLE_AW'(NUM_SAMPLES - 1));
  assign last_epoch  = (epoch_inc == 4'(NUM_EPOCHS));
  assign upd_x       = scan[2:0];
  assign upd_y       = scan[5:3];

`ifdef SOM_EARLY_STOP_EN
  localparam int unsigned CHG_W = $clog2(NUM_SAMPLES + 1);

  logic [5:0]       win_mem [NUM_SAMPLES];
  logic [CHG_W-1:0] chg_cnt;
  logic             win_changed;

  assign win_changed = (win_mem[sample_addr] != {winner_y_in, winner_x_in});
  // Convergence only counts once a previous epoch exists to compare against.
  assign stop_early  = (epoch != 4'd0) && (chg_cnt == CHG_W'(0));

  // Winner history, written at capture time; read only from epoch 1 on.
  always_ff @(posedge clk) begin
    if (state == S_CAPT) begin
      win_mem[sample_addr] <= {winner_y_in, winner_x_in};
    end
  end
`else
  assign stop_early = 1'b0;
`endif

  // Main sequencer; all outputs are registered on state entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_addr <= '0;
      sample_load <= 1'b0;
      win_x       <= 3'd0;
      win_y       <= 3'd0;
      upd_en      <= 1'b0;
      scan        <= '0;
      lr_shift    <= 3'd0;
      epoch       <= 4'd0;
      radius      <= 3'd0;
      wait_cnt    <= '0;
`ifdef SOM_EARLY_STOP_EN
      chg_cnt       <= '0;
      stopped_early <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      sample_load <= 1'b0;
      upd_en      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            busy        <= 1'b1;
            sample_load <= 1'b1;
            epoch       <= 4'd0;
            sample_addr <= '0;
            radius      <= 3'(INIT_RADIUS);
            lr_shift    <= 3'(INIT_SHIFT);
`ifdef SOM_EARLY_STOP_EN
            chg_cnt       <= '0;
            stopped_early <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_W'(DIST_LAT - 1)) begin
            state <= S_CAPT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CAPT: begin
          // Enable for idx 0 uses the winner being captured this edge.
          win_x  <= winner_x_in;
          win_y  <= winner_y_in;
          scan   <= '0;
          upd_en <= in_hood(3'd0, 3'd0, winner_x_in, winner_y_in, radius);
          state  <= S_UPD;
`ifdef SOM_EARLY_STOP_EN
          if ((epoch != 4'd0) && win_changed) begin
            chg_cnt <= chg_cnt + 1'b1;
          end
`endif
        end
        S_UPD: begin
          if (scan == 6'd63) begin
            scan  <= '0;
            state <= S_NEXT;
          end else begin
            scan   <= scan_inc;
            upd_en <= in_hood(scan_inc[2:0], scan_inc[5:3], win_x, win_y, radius);
          end
        end
        S_NEXT: begin
          if (!last_sample) begin
            sample_addr <= sample_addr + 1'b1;
            sample_load <= 1'b1;
            state       <= S_LOAD;
          end else begin
            sample_addr <= '0;
            epoch       <= epoch_inc;
            radius      <= (radius != 3'd0) ? (radius - 3'd1) : 3'd0;
            lr_shift    <= (lr_shift != 3'd7) ? (lr_shift + 3'd1) : 3'd7;
`ifdef SOM_EARLY_STOP_EN
            chg_cnt <= '0;
            if (stop_early && !last_epoch) begin
              stopped_early <= 1'b1;
            end
`endif
            if (last_epoch || stop_early) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              sample_load <= 1'b1;
              state       <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
